// File: rtl/elevator_car.sv
// elevator_car: cycle-based car/shaft plant driven by controller motor/direction commands.
// Optional ELEVATOR_CAR_TRIP_CNT_EN adds a saturating trip_count output.
module elevator_car #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES = 6,
  parameter int HOME_FLOOR = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] motor,
  input  logic       dir_up,
  input  logic       dir_down,
  output logic [1:0] current_floor,
  output logic       moving,
  output logic       at_floor,
  output logic [3:0] served,
  output logic       door_open,
  output logic       fault
`ifdef ELEVATOR_CAR_TRIP_CNT_EN
  ,
  output logic [15:0] trip_count
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVING = 2'd1;
  localparam logic [1:0] ARRIVE = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;
  localparam logic [15:0] TMAX = 16'(TRAVEL_CYCLES - 1);
  localparam logic [15:0] DMAX = 16'(DOOR_CYCLES - 1);
  logic [1:0] state, nxt_state, nxt_floor, new_floor;
  logic [15:0] tcnt, nxt_tcnt, dcnt, nxt_dcnt;
  logic up, nxt_up, nxt_at, nxt_fault, seg_end, keep_going;
  logic [3:0] nxt_served;
  assign new_floor = up ? current_floor + 2'd1 : current_floor - 2'd1;
  // a valid continuation needs the latched direction alone plus some pending stop
  assign keep_going = (up ? (dir_up && !dir_down) : (dir_down && !dir_up)) && motor != 4'd0
                      && !motor[new_floor] && new_floor != (up ? 2'd3 : 2'd0);
  always_comb begin
    nxt_state = state;
    nxt_floor = current_floor;
    nxt_tcnt = tcnt;
    nxt_dcnt = dcnt;
    nxt_up = up;
    nxt_served = 4'd0;
    nxt_at = 1'b0;
    nxt_fault = 1'b0;
    seg_end = 1'b0;
    case (state)
      IDLE:
        if (dir_up && dir_down) nxt_fault = 1'b1;
        else if (motor[current_floor]) begin
          nxt_state = DOOR_OPEN;
          nxt_served = 4'b0001 << current_floor;
          nxt_dcnt = 16'd0;
        end else if ((dir_up && current_floor == 2'd3) || (dir_down && current_floor == 2'd0))
          nxt_fault = 1'b1;
        else if ((dir_up || dir_down) && motor != 4'd0) begin
          nxt_state = MOVING;
          nxt_up = dir_up;
          nxt_tcnt = 16'd0;
        end
      MOVING:
        if (tcnt == TMAX) begin
          seg_end = 1'b1;
          nxt_floor = new_floor;
          nxt_tcnt = 16'd0;
          nxt_fault = dir_up && dir_down;
          if (!keep_going) begin
            nxt_state = ARRIVE;
            nxt_at = 1'b1;
            nxt_served = motor[new_floor] ? 4'b0001 << new_floor : 4'd0;
          end
        end else nxt_tcnt = tcnt + 16'd1;
      ARRIVE: begin
        nxt_state = served != 4'd0 ? DOOR_OPEN : IDLE;
        nxt_dcnt = 16'd0;
      end
      default:
        if (dcnt == DMAX) nxt_state = IDLE;
        else nxt_dcnt = dcnt + 16'd1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      current_floor <= 2'(HOME_FLOOR);
      tcnt <= 16'd0;
      dcnt <= 16'd0;
      up <= 1'b1;
      served <= 4'd0;
      at_floor <= 1'b0;
      fault <= 1'b0;
      moving <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state <= nxt_state;
      current_floor <= nxt_floor;
      tcnt <= nxt_tcnt;
      dcnt <= nxt_dcnt;
      up <= nxt_up;
      served <= nxt_served;
      at_floor <= nxt_at;
      fault <= nxt_fault;
      moving <= nxt_state == MOVING;
      door_open <= nxt_state == DOOR_OPEN;
    end
  end
`ifdef ELEVATOR_CAR_TRIP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) trip_count <= 16'd0;
    else if (seg_end && trip_count != 16'hFFFF) trip_count <= trip_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_elevator_car.sv
// tb_elevator_car: directed literal checks plus randomized commands against a behavioural car model.
module tb_elevator_car;
  localparam int TRAVEL = 8;
  localparam int DOOR = 6;
  localparam int HOME = 0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] motor = 4'd0;
  logic dir_up = 1'b0;
  logic dir_down = 1'b0;
  logic [1:0] current_floor;
  logic moving, at_floor, door_open, fault;
  logic [3:0] served;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
`ifdef ELEVATOR_CAR_TRIP_CNT_EN
  logic [15:0] trip_count;
`endif

  elevator_car #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR), .HOME_FLOOR(HOME)) dut (
    .clk(clk), .reset(reset), .motor(motor), .dir_up(dir_up), .dir_down(dir_down),
    .current_floor(current_floor), .moving(moving), .at_floor(at_floor), .served(served),
    .door_open(door_open), .fault(fault)
`ifdef ELEVATOR_CAR_TRIP_CNT_EN
    , .trip_count(trip_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: floor as an int, direction as +1/-1, door as a countdown of remaining open cycles.
  int mf, mt, mdir, mdoor, mtrip;
  bit mmv, marr, marr_serve, e_at, e_fault;
  logic [3:0] e_served;

  always @(posedge clk) begin
    e_at = 1'b0;
    e_fault = 1'b0;
    e_served = 4'd0;
    if (reset) begin
      mf = HOME; mt = 0; mdir = 1; mdoor = 0; mmv = 0; marr = 0; marr_serve = 0; mtrip = 0;
    end else if (mdoor > 0) mdoor--;
    else if (marr) begin
      marr = 0;
      if (marr_serve) mdoor = DOOR;
    end else if (mmv) begin
      mt++;
      if (mt == TRAVEL) begin
        mf += mdir;
        mt = 0;
        if (mtrip < 65535) mtrip++;
        e_fault = dir_up && dir_down;
        if (motor[mf] || mf == (mdir > 0 ? 3 : 0) || motor == 4'd0 ||
            !(mdir > 0 ? (dir_up && !dir_down) : (dir_down && !dir_up))) begin
          mmv = 0;
          marr = 1;
          e_at = 1'b1;
          marr_serve = motor[mf];
          if (motor[mf]) e_served = 4'(1 << mf);
        end
      end
    end else begin
      if (dir_up && dir_down) e_fault = 1'b1;
      else if (motor[mf]) begin
        mdoor = DOOR;
        e_served = 4'(1 << mf);
      end else if ((dir_up && mf == 3) || (dir_down && mf == 0)) e_fault = 1'b1;
      else if ((dir_up || dir_down) && motor != 4'd0) begin
        mmv = 1;
        mt = 0;
        mdir = dir_up ? 1 : -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("floor", 32'(current_floor), 32'(mf));
    chk("moving", 32'(moving), 32'(mmv));
    chk("at_floor", 32'(at_floor), 32'(e_at));
    chk("served", 32'(served), 32'(e_served));
    chk("door_open", 32'(door_open), 32'(mdoor > 0));
    chk("fault", 32'(fault), 32'(e_fault));
`ifdef ELEVATOR_CAR_TRIP_CNT_EN
    chk("trip_count", 32'(trip_count), 32'(mtrip));
`endif
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] m, input logic u, input logic d);
    motor = m; dir_up = u; dir_down = d;
  endtask

  initial begin
    edges(2);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("lit_reset_floor", 32'(current_floor), 32'(HOME));
    chk("lit_reset_door", 32'(door_open), 0);
    drive(4'b1000, 1'b1, 1'b0);
    edges(1);
    chk("lit_e0_moving", 32'(moving), 1);
    edges(8);
    chk("lit_e8_floor", 32'(current_floor), 1);
    edges(16);
    chk("lit_e24_floor", 32'(current_floor), 3);
    chk("lit_e24_at", 32'(at_floor), 1);
    chk("lit_e24_served", 32'(served), 32'b1000);
    edges(1);
    chk("lit_e25_door", 32'(door_open), 1);
`ifdef ELEVATOR_CAR_TRIP_CNT_EN
    chk("lit_trips", 32'(trip_count), 3);
`endif
    edges(5);
    chk("lit_e30_door", 32'(door_open), 1);
    edges(1);
    chk("lit_e31_door", 32'(door_open), 0);
    chk("lit_e31_moving", 32'(moving), 0);
    drive(4'b0000, 1'b0, 1'b0);
    edges(2);
    drive(4'b1000, 1'b0, 1'b0);
    edges(1);
    chk("lit_same_served", 32'(served), 32'b1000);
    chk("lit_same_at", 32'(at_floor), 0);
    chk("lit_same_door", 32'(door_open), 1);
    drive(4'b0000, 1'b0, 1'b0);
    edges(8);
    drive(4'b0001, 1'b1, 1'b0);
    edges(1);
    chk("lit_overtravel_fault", 32'(fault), 1);
    chk("lit_overtravel_still", 32'(moving), 0);
    drive(4'b0001, 1'b1, 1'b1);
    edges(1);
    chk("lit_both_fault", 32'(fault), 1);
    drive(4'b0000, 1'b0, 1'b0);
    edges(2);
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        motor = 4'($urandom_range(0, 15));
        dir_up = r < 4 || r == 8;
        dir_down = (r >= 4 && r < 8) || r == 8;
      end
      reset = $urandom_range(0, 299) == 0;
      edges(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_car.md
Name: elevator_car

Overview:
- Cycle-based plant model of the elevator car and shaft: the other end of the controller's motor/direction interface.
- Consumes the controller's motor and dir_up/dir_down commands, moves the car floor-by-floor with a fixed travel time, runs a door cycle at served floors, and drives current_floor back to the controller.
- Used in closed-loop simulation in place of hand-driven floor stimulus; synthesizable for board demos.

Parameters:
- TRAVEL_CYCLES, 8: clocks per floor-to-floor segment (>=2).
- DOOR_CYCLES, 6: clocks door_open stays high (>=1).
- HOME_FLOOR, 0: floor loaded on reset (0..3).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- motor  input  4  stop request per floor from controller, bit f = stop at floor f; drive enabled when nonzero.
- dir_up  input  1  move-up command.
- dir_down  input  1  move-down command.
- current_floor  output  2  registered car floor position.
- moving  output  1  high in MOVING.
- at_floor  output  1  one-cycle pulse on each floor arrival that ends travel.
- served  output  4  one-cycle one-hot pulse, floor whose request was served.
- door_open  output  1  high during DOOR_OPEN.
- fault  output  1  one-cycle pulse on illegal command.

Behaviour:
- Reset (sampled on clk edge): state=IDLE, current_floor=HOME_FLOOR, travel counter=0, door counter=0, latched dir=up, all other outputs 0. Reset mid-travel or mid-door aborts immediately to these values.
- States: IDLE, MOVING, ARRIVE, DOOR_OPEN. All outputs registered.
- IDLE priority, evaluated each edge:
  1. dir_up&dir_down -> fault pulse, stay IDLE.
  2. motor[current_floor]=1 -> DOOR_OPEN, served[current_floor] pulse same cycle, at_floor stays 0.
  3. dir_up with current_floor=3, or dir_down with current_floor=0 -> fault pulse (overtravel), stay IDLE.
  4. Exactly one dir asserted and motor!=0 -> MOVING, latch direction, travel counter=0.
  5. Otherwise stay IDLE.
- MOVING:
  - Counter increments each edge. On the edge where it would reach TRAVEL_CYCLES, current_floor changes by +/-1 (latched dir) and the counter clears.
  - Leave for ARRIVE on that same edge if any of: motor[new floor]=1, new floor is an end stop in the travel direction, or no valid command present (dir for latched direction low, or both dirs high, or motor=0). Otherwise continue MOVING.
  - Commands are sampled only at segment end. The car never stops between floors, and reversal mid-segment is ignored.
  - Both dirs high at segment end -> stop in ARRIVE plus fault pulse.
- ARRIVE (1 cycle):
  - at_floor=1.
  - If motor[current_floor]=1: served[current_floor]=1, next DOOR_OPEN. Else next IDLE.
- DOOR_OPEN:
  - door_open=1 for exactly DOOR_CYCLES cycles, then IDLE.
  - Direction commands ignored (door interlock), no fault raised.
  - motor bits ignored; no re-serve until IDLE.
- current_floor never leaves 0..3; the wrap 3->0 is impossible by construction.

Optional Feature:
- Macro ELEVATOR_CAR_TRIP_CNT_EN.
- Defined: adds output trip_count [15:0]. Increments on every completed floor-to-floor segment, saturates at 16'hFFFF, resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Up trip (defaults): reset, floor 0; motor=4'b1000, dir_up=1 sampled at edge E0 -> moving=1 from E0; current_floor=1 at E8, 2 at E16, 3 at E24; at_floor=1 and served=4'b1000 for cycle E24-E25; door_open=1 E25..E30; IDLE, moving=0 at E31.
- Intermediate stop: from floor 3, motor=4'b0101, dir_down -> car stops at floor 2 after 8 cycles, served=4'b0100, door runs 6 cycles. Controller then keeps dir_down with motor=4'b0001 -> car reaches floor 0, served=4'b0001.
- Same-floor request: idle at floor 2, motor=4'b0100, no dir -> next edge door_open=1, served=4'b0100, current_floor unchanged, at_floor=0.
- Illegal commands: at floor 3, dir_up=1, motor=4'b1000 -> serves floor 3 (rule 2 priority). With motor=4'b0001, dir_up=1 -> fault pulse, no motion. dir_up=dir_down=1 in IDLE -> fault, no motion. Mid-segment flip to dir_down -> ignored until segment end.
- Interlock and drop: dir_up asserted during DOOR_OPEN -> no motion, no fault until door closes. Command dropped mid-segment -> segment completes, car stops at next floor with at_floor=1, served=0, returns to IDLE.
- Reset mid-operation: reset at E12 of an up trip -> next edge current_floor=0 (HOME_FLOOR), moving=0, door_open=0. With ELEVATOR_CAR_TRIP_CNT_EN, 0->3 trip gives trip_count=3 and reset clears it.
